mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/minrv32_mem_pkg.sv | 16 +
 rtl/mem_arbiter_rr.sv | 36 +++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/minrv32_mem_pkg.sv
// Shared definitions for the minrv32 memory arbiter: FSM state encoding
// and bus width constants.
package minrv32_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Arbiter FSM states: idle, or serving master 0 / master 1.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin picker. On a tie the master that was not granted
// last time wins; a lone request always wins.
module mem_arbiter_rr
    import minrv32_mem_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    // Pick the winning master index from the current requests.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = 1'b0;
        case (req_i)
            2'b01: begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = 1'b0;
            end
            2'b10: begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = 1'b1;
            end
            2'b11: begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = ~last_grant_i;
            end
            default: begin
                gnt_valid_o = 1'b0;
                gnt_idx_o   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter (fetch = master 0, data = master 1) in front of
// a single downstream memory port. One transaction at a time; a watchdog
// forces completion when memory stalls for TIMEOUT_CYCLES busy cycles.
module mem_arbiter
    import minrv32_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              m0_valid,
    input  logic              m0_instr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_valid,
    input  logic              m1_instr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mem_valid,
    output logic              mem_instr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              grant,
    output logic              timeout
);

    // Counter just wide enough to hold TIMEOUT_CYCLES (at least one bit).
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;

    logic             rr_valid_s;
    logic             rr_idx_s;
    logic             sel_s;
    logic             to_hit_s;

    mem_arbiter_rr u_rr (
        .req_i        ({m1_valid, m0_valid}),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (rr_valid_s),
        .gnt_idx_o    (rr_idx_s)
    );

    // The current busy cycle is the TIMEOUT_CYCLES-th one without mem_ready.
    assign to_hit_s = TIMEOUT_EN && (cnt_q == CNT_LAST);
    assign sel_s    = (state_q == BUSY1);

    // State, stall counter and round-robin history registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic, downstream request mux and completion routing.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        mem_valid    = 1'b0;
        mem_instr    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wstrb    = '0;
        m0_ready     = 1'b0;
        m0_rdata     = '0;
        m1_ready     = 1'b0;
        m1_rdata     = '0;
        busy         = 1'b0;
        grant        = 1'b0;
        timeout      = 1'b0;

        case (state_q)
            IDLE: begin
                // Counter starts from zero on every entry to a busy state;
                // mem_ready is deliberately ignored here.
                cnt_d = '0;
                if (rr_valid_s) begin
                    state_d      = rr_idx_s ? BUSY1 : BUSY0;
                    last_grant_d = rr_idx_s;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY0, BUSY1: begin
                busy      = 1'b1;
                grant     = sel_s;
                mem_valid = 1'b1;
                if (sel_s) begin
                    mem_instr = m1_instr;
                    mem_addr  = m1_addr;
                    mem_wdata = m1_wdata;
                    mem_wstrb = m1_wstrb;
                end else begin
                    mem_instr = m0_instr;
                    mem_addr  = m0_addr;
                    mem_wdata = m0_wdata;
                    mem_wstrb = m0_wstrb;
                end

                if (mem_ready) begin
                    // Normal completion beats a coincident timeout.
                    state_d = IDLE;
                    if (sel_s) begin
                        m1_ready = 1'b1;
                        m1_rdata = mem_rdata;
                    end else begin
                        m0_ready = 1'b1;
                        m0_rdata = mem_rdata;
                    end
                end else if (to_hit_s) begin
                    // Forced completion with zero read data.
                    state_d = IDLE;
                    timeout = 1'b1;
                    if (sel_s) begin
                        m1_ready = 1'b1;
                    end else begin
                        m0_ready = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT_CYCLES = 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        busy, grant, timeout;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .m0_valid  (m0_valid),
        .m0_instr  (m0_instr),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_wstrb  (m0_wstrb),
        .m0_ready  (m0_ready),
        .m0_rdata  (m0_rdata),
        .m1_valid  (m1_valid),
        .m1_instr  (m1_instr),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_wstrb  (m1_wstrb),
        .m1_ready  (m1_ready),
        .m1_rdata  (m1_rdata),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .grant     (grant),
        .timeout   (timeout)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    // Every output in one go against a full expectation.
    task automatic check_all(input string tag, input logic e_busy, input logic e_grant,
                             input logic e_to, input logic e_r0, input logic e_r1,
                             input logic e_mv);
        check_eq({tag, ".busy"},      {31'd0, busy},      {31'd0, e_busy});
        check_eq({tag, ".grant"},     {31'd0, grant},     {31'd0, e_grant});
        check_eq({tag, ".timeout"},   {31'd0, timeout},   {31'd0, e_to});
        check_eq({tag, ".m0_ready"},  {31'd0, m0_ready},  {31'd0, e_r0});
        check_eq({tag, ".m1_ready"},  {31'd0, m1_ready},  {31'd0, e_r1});
        check_eq({tag, ".mem_valid"}, {31'd0, mem_valid}, {31'd0, e_mv});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        m0_valid  = 1'b0; m0_instr = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        m1_valid  = 1'b0; m1_instr = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;

        // ---- reset state ----
        do_reset();
        sample();
        check_all("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst.mem_addr", mem_addr, 32'h0);
        check_eq("rst.m0_rdata", m0_rdata, 32'h0);

        // ---- single fetch, memory answers on the 2nd busy cycle ----
        tick();
        m0_valid = 1'b1; m0_instr = 1'b1; m0_addr = 32'h0001_0000; m0_wstrb = 4'h0;
        tick();
        sample();
        check_all("fetch.b1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("fetch.mem_addr", mem_addr, 32'h0001_0000);
        check_eq("fetch.mem_instr", {31'd0, mem_instr}, 32'd1);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
        sample();
        check_all("fetch.b2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("fetch.m0_rdata", m0_rdata, 32'h0000_0013);
        check_eq("fetch.m1_rdata", m1_rdata, 32'h0);
        tick();
        m0_valid = 1'b0; mem_ready = 1'b0;
        sample();
        check_all("fetch.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---- contention from reset: grants alternate 0,1,0,1 ----
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h0000_0100;
        m1_valid = 1'b1; m1_addr = 32'h0000_0200; m1_instr = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            logic eg;
            eg = (i % 2 == 1);
            tick();
            sample();
            check_all($sformatf("cont%0d", i), 1'b1, eg, 1'b0, ~eg, eg, 1'b1);
            check_eq($sformatf("cont%0d.mem_addr", i), mem_addr,
                     eg ? 32'h0000_0200 : 32'h0000_0100);
            tick();
            if (i == 3) begin
                m0_valid = 1'b0; m1_valid = 1'b0; mem_ready = 1'b0;
            end
            sample();
            check_eq($sformatf("cont%0d.idle", i), {31'd0, busy}, 32'd0);
        end

        // ---- write forwarding from master 1 ----
        m0_addr = 32'h5555_5555; m0_wdata = 32'h6666_6666; m0_wstrb = 4'h3; m0_instr = 1'b1;
        m1_valid = 1'b1; m1_instr = 1'b0; m1_addr = 32'h0002_0004;
        m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF;
        tick();
        sample();
        check_all("wr.b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("wr.mem_addr", mem_addr, 32'h0002_0004);
        check_eq("wr.mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check_eq("wr.mem_wstrb", {28'd0, mem_wstrb}, 32'hF);
        check_eq("wr.mem_instr", {31'd0, mem_instr}, 32'd0);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h0;
        sample();
        check_all("wr.done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        m1_valid = 1'b0; mem_ready = 1'b0;
        sample();
        check_all("wr.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---- timeout: 4th stalled busy cycle forces completion ----
        m0_valid = 1'b1; m0_instr = 1'b0; m0_addr = 32'h0000_0040; m0_wstrb = 4'h0;
        mem_rdata = 32'hAAAA_5555;
        for (int c = 1; c <= 4; c++) begin
            tick();
            sample();
            if (c < 4) begin
                check_all($sformatf("to.c%0d", c), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end else begin
                check_all("to.c4", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
                check_eq("to.m0_rdata", m0_rdata, 32'h0);
            end
        end
        tick();
        m0_valid = 1'b0;
        sample();
        check_all("to.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---- mem_ready coincident with timeout: normal completion wins ----
        m0_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 4) mem_ready = 1'b1;
            sample();
        end
        check_all("prio.c4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("prio.m0_rdata", m0_rdata, 32'hAAAA_5555);
        tick();
        m0_valid = 1'b0; mem_ready = 1'b0;

        // ---- reset in BUSY1, then a tie goes to master 0 ----
        m1_valid = 1'b1; m1_addr = 32'h0000_0300;
        tick();
        sample();
        check_all("rmid.busy1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; m0_valid = 1'b1; m1_valid = 1'b1; mem_rdata = 32'h0;
        sample();
        check_all("rmid.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rmid.mem_addr", mem_addr, 32'h0);
        tick();
        sample();
        check_all("rmid.tie", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        m0_valid = 1'b0; m1_valid = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h0000_0001;
        sample();
        check_all("rmid.done", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        mem_ready = 1'b0;

        // ---- mem_ready pulsed while idle is ignored ----
        tick();
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        sample();
        check_all("idle_rdy", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("idle_rdy.m0_rdata", m0_rdata, 32'h0);
        tick();
        mem_ready = 1'b0;
        sample();
        check_all("idle_rdy.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
